// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, writeback select,
// FSM states and the byte-lane enable decode.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC8 = 2'b10;

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    // Lane enables within the low 32-bit word; size 2'b11 decodes as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] o;
        case (size)
            SZ_BYTE: o = off;
            SZ_HALF: o = {off[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dmem_be.sv
// Data memory: synchronous byte-enable write, asynchronous read, no reset of contents.
module dmem_be #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS),
    localparam int unsigned NB         = XLEN / 8
) (
    input  logic            clk,
    input  logic [NB-1:0]   we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_pipe.sv
// EX/MEM pipeline register plus data-memory access with configurable latency.
// Define MEM_STAGE_MISALIGN_EN to flag misaligned accesses instead of masking low address bits.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned MEM_LAT     = 0,
    parameter int unsigned REG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_in,
    input  logic             flush_in,
    input  logic             valid_e,
    input  logic             jump_e,
    input  logic             regwrite_e,
    input  logic             memread_e,
    input  logic             memwrite_e,
    input  logic             memsigned_e,
    input  logic [1:0]       memsize_e,
    input  logic [1:0]       memtoreg_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic [XLEN-1:0]  aluout_e,
    input  logic [XLEN-1:0]  writedata_e,
    input  logic [XLEN-1:0]  pcplus4_e,
    output logic             valid_m,
    output logic             jump_m,
    output logic             regwrite_m,
    output logic [1:0]       memtoreg_m,
    output logic [REG_W-1:0] writereg_m,
    output logic [XLEN-1:0]  aluout_m,
    output logic [XLEN-1:0]  pcplus8_m,
    output logic [XLEN-1:0]  readdata_m,
    output logic             mem_busy,
    output logic             misalign_m
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam int unsigned NB  = XLEN / 8;
    localparam logic [2:0]  LAT = 3'(MEM_LAT);

    logic             valid_q, jump_q, regwrite_q, memread_q, memwrite_q, memsigned_q;
    logic [1:0]       memsize_q, memtoreg_q;
    logic [REG_W-1:0] writereg_q;
    logic [XLEN-1:0]  aluout_q, writedata_q, pcplus8_q;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    logic            capture, mis_e, mis_m, access_e, access_m, complete, store_en;
    logic [1:0]      off_m;
    logic [3:0]      be4;
    logic [NB-1:0]   we;
    logic [XLEN-1:0] wdata, rdata, ext;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    assign capture = !(hold_in | mem_busy);

`ifdef MEM_STAGE_MISALIGN_EN
    assign mis_e = is_misaligned(memsize_e, aluout_e[1:0]);
    assign mis_m = valid_q & (memread_q | memwrite_q) & is_misaligned(memsize_q, aluout_q[1:0]);
    assign off_m = aluout_q[1:0];
`else
    assign mis_e = 1'b0;
    assign mis_m = 1'b0;
    assign off_m = align_off(memsize_q, aluout_q[1:0]);
`endif

    assign access_e = valid_e & (memread_e | memwrite_e) & !mis_e;
    assign access_m = valid_q & (memread_q | memwrite_q) & !mis_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            jump_q      <= 1'b0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            memsigned_q <= 1'b0;
            memsize_q   <= 2'b00;
            memtoreg_q  <= 2'b00;
            writereg_q  <= '0;
            aluout_q    <= '0;
            writedata_q <= '0;
            pcplus8_q   <= '0;
        end else if (flush_in) begin
            // Bubble: only the control fields matter, data fields are left as-is.
            valid_q     <= 1'b0;
            jump_q      <= 1'b0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            memsigned_q <= 1'b0;
            memsize_q   <= 2'b00;
            memtoreg_q  <= 2'b00;
        end else if (capture) begin
            valid_q     <= valid_e;
            jump_q      <= jump_e;
            regwrite_q  <= regwrite_e;
            memread_q   <= memread_e;
            memwrite_q  <= memwrite_e;
            memsigned_q <= memsigned_e;
            memsize_q   <= memsize_e;
            memtoreg_q  <= memtoreg_e;
            writereg_q  <= writereg_e;
            aluout_q    <= aluout_e;
            writedata_q <= writedata_e;
            pcplus8_q   <= pcplus4_e + XLEN'(4);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_in) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = StIdle;
            end
        end else if (capture && access_e && (MEM_LAT > 0)) begin
            state_d = StWait;
            cnt_d   = LAT;
        end
    end

    // A store stays in M in IDLE after completing (hold, or post-WAIT); done_q blocks a rewrite.
    assign complete = (state_q == StIdle) || ((cnt_q == 3'd1) && !flush_in);
    assign store_en = access_m & memwrite_q & !done_q & complete;

    always_comb begin
        done_d = done_q;
        if (flush_in || capture) begin
            done_d = 1'b0;
        end else if (store_en) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign be4 = byte_en(memsize_q, off_m);

    always_comb begin
        we = '0;
        for (int b = 0; b < NB; b++) begin
            we[b] = store_en & ((b < 4) ? be4[2'(b)] : memsize_q[1]);
        end
    end

    always_comb begin
        wdata = writedata_q;
        if (memsize_q == SZ_BYTE) begin
            for (int b = 0; b < NB; b++) wdata[8*b +: 8] = writedata_q[7:0];
        end else if (memsize_q == SZ_HALF) begin
            for (int b = 0; b < NB / 2; b++) wdata[16*b +: 16] = writedata_q[15:0];
        end
    end

    dmem_be #(
        .XLEN       (XLEN),
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_dmem (
        .clk  (clk),
        .we   (we),
        .addr (aluout_q[2 +: AW]),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_comb begin
        rbyte = rdata[{off_m, 3'b000} +: 8];
        rhalf = off_m[1] ? rdata[31:16] : rdata[15:0];
        case (memsize_q)
            SZ_BYTE: ext = {{(XLEN-8){memsigned_q & rbyte[7]}}, rbyte};
            SZ_HALF: ext = {{(XLEN-16){memsigned_q & rhalf[15]}}, rhalf};
            default: ext = rdata;
        endcase
    end

    assign readdata_m = (valid_q & memread_q & !mis_m) ? ext : '0;
    assign valid_m    = valid_q;
    assign jump_m     = jump_q;
    assign regwrite_m = regwrite_q & !mis_m;
    assign memtoreg_m = memtoreg_q;
    assign writereg_m = writereg_q;
    assign aluout_m   = aluout_q;
    assign pcplus8_m  = pcplus8_q;
    assign mem_busy   = (state_q == StWait);
    assign misalign_m = mis_m;

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised EX/MEM pipeline register plus data-memory access stage for the pipelined MIPS core.
- Supports byte, halfword and word loads/stores with sign/zero extension.
- Models a configurable-latency data memory; raises a stall request to the hazard unit while an access is outstanding.
- Accepts hold and flush, and flags misaligned accesses.

Parameters:
- XLEN, 32, datapath width (multiple of 8, >=32).
- DEPTH_WORDS, 1024, data-memory depth in XLEN words (power of 2).
- MEM_LAT, 0, extra wait cycles per load/store (0..7).
- REG_W, 5, register-file index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- hold_in  in  1  hazard unit holds M register (downstream stall).
- flush_in  in  1  turn M-stage contents into a bubble.
- valid_e  in  1  E-stage instruction valid.
- jump_e, regwrite_e, memread_e, memwrite_e, memsigned_e  in  1 each  E-stage controls.
- memsize_e  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- memtoreg_e  in  2  writeback select, passed through.
- writereg_e  in  REG_W  destination register.
- aluout_e, writedata_e, pcplus4_e  in  XLEN each  address/ALU result, store data, PC+4.
- valid_m, jump_m, regwrite_m  out  1 each  registered controls.
- memtoreg_m  out  2  registered.
- writereg_m  out  REG_W  registered.
- aluout_m, pcplus8_m, readdata_m  out  XLEN each  registered ALU result, PC+8, extended load data.
- mem_busy  out  1  stall request: M holds an access not yet complete.
- misalign_m  out  1  M-stage access misaligned.

Behaviour:
- Reset (async): all M-register fields 0, wait counter 0, mem_busy 0, misalign_m 0. Memory contents are not cleared.
- Capture: M register loads E inputs on posedge when !(hold_in | mem_busy). Otherwise it holds.
- Capture latency: 1 cycle E->M. pcplus8_m = registered pcplus4 + 4, mod 2^XLEN.
- FSM, states IDLE and WAIT:
  - An access (valid & (memread | memwrite) & !misaligned) entering M with MEM_LAT>0: counter = MEM_LAT, state WAIT.
  - mem_busy = (state==WAIT). Counter decrements each cycle; WAIT->IDLE when the counter reaches 0.
  - MEM_LAT=0: never enters WAIT; mem_busy stays 0.
- Access completes on the last M cycle (IDLE, or WAIT with counter==1).
- Stores: commit on the completing edge, exactly once per instruction, including under hold_in. Per-byte write enables come from aluout[1:0] and memsize. Store data is replicated to all lanes: byte x4, half x2.
- Loads: readdata_m is combinational from the array at the registered address. It is valid whenever !mem_busy. The selected lane is sign- or zero-extended per memsigned.
- Word index = aluout_m[2+log2(DEPTH_WORDS)-1:2]; upper bits ignored (wrap).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0:
  - misalign_m=1; store suppressed; regwrite_m forced 0; no WAIT.
- flush_in: takes priority over capture. Next M contents become a bubble (all controls 0, data fields don't-care). If in WAIT, state goes to IDLE, counter clears, and the pending store is dropped.
- hold_in and mem_busy together: hold; counter continues.
- Non-memory instructions pass through with no wait.

Optional Feature:
- MEM_STAGE_MISALIGN_EN defined: misalignment detection as above.
- Undefined: low address bits are masked to size alignment (half: addr[0]=0, word: addr[1:0]=0). misalign_m is tied 0 and the access proceeds normally.

Decomposition:
- Package mem_stage_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD); memtoreg encodings; FSM state typedef; byte-enable function.
- One sub-module, dmem_be: byte-enable synchronous-write, async-read RAM, parametrised by XLEN and DEPTH_WORDS.

Test Plan:
- MEM_LAT=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> readdata_m=0xDEADBEEF next cycle, mem_busy never 1.
- sb 0x80 @0x13, lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lh @0x12 -> 0xFFFF80AD after sw 0xDEADBEEF@0x10 then sb.
- MEM_LAT=3: lw entering M -> mem_busy high 3 cycles, E inputs held off, readdata_m valid on 4th cycle, store writes once.
- Misaligned lw @0x11 with MEM_STAGE_MISALIGN_EN -> misalign_m=1, regwrite_m=0, memory unchanged; without the macro -> reads word @0x10.
- flush_in during WAIT of sw @0x20 (MEM_LAT=2) -> mem_busy drops next cycle, word @0x20 unchanged.
- rst asserted mid-WAIT -> all outputs 0 immediately; prior memory contents retained; pcplus8_m=0x4 after capture of pcplus4_e=0.
